// File: rtl/multiplicador_secuencial.sv
// Iterative signed multiplier: radix-2 Booth, one step per clock, start/busy/done handshake.
// Produces the exact 2N-bit product (Q(5.19) x Q(10.14) -> Q(15.33) for N = 25).
module multiplicador_secuencial #(
   parameter int unsigned N = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Inicio,
   input  logic [N-1:0]     Dato_A,
   input  logic [N-1:0]     Dato_B,
   output logic             Ocupado,
   output logic             Listo,
   output logic [2*N-1:0]   Datos_Mult
);

   localparam int unsigned CntW = $clog2(N + 1);

   typedef enum logic [0:0] {StIdle, StCalc} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]      m_q, m_d;
   logic [2*N:0]      p_q, p_d;
   logic [2*N-1:0]    prod_q, prod_d;
   logic              listo_q, listo_d;
   logic              ocup_q, ocup_d;

   logic [N:0]        hi_ext;
   logic [N:0]        m_ext;
   logic [N:0]        sum;
   logic [2*N:0]      p_step;

   // The extra accumulator bit keeps M = -2^(N-1) exact; the shift drops the old LSB.
   always_comb begin
      hi_ext = {p_q[2*N], p_q[2*N:N+1]};
      m_ext  = {m_q[N-1], m_q};
      unique case (p_q[1:0])
         2'b01:   sum = hi_ext + m_ext;
         2'b10:   sum = hi_ext - m_ext;
         default: sum = hi_ext;
      endcase
      p_step = {sum, p_q[N:1]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      p_d     = p_q;
      prod_d  = prod_q;
      listo_d = 1'b0;
      ocup_d  = ocup_q;
      unique case (state_q)
         StIdle: begin
            if (Inicio) begin
               m_d     = Dato_A;
               p_d     = {{N{1'b0}}, Dato_B, 1'b0};
               cnt_d   = CntW'(N);
               ocup_d  = 1'b1;
               state_d = StCalc;
            end
         end
         StCalc: begin
            p_d   = p_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               prod_d  = p_step[2*N:1];
               listo_d = 1'b1;
               ocup_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         m_q     <= '0;
         p_q     <= '0;
         prod_q  <= '0;
         listo_q <= 1'b0;
         ocup_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         p_q     <= p_d;
         prod_q  <= prod_d;
         listo_q <= listo_d;
         ocup_q  <= ocup_d;
      end
   end

   assign Ocupado    = ocup_q;
   assign Listo      = listo_q;
   assign Datos_Mult = prod_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial: directed cases plus a random sweep
// against a plain-arithmetic product reference.
module tb_multiplicador_secuencial;

   localparam int N = 25;

   logic                clk;
   logic                rst_n;
   logic                Inicio;
   logic signed [N-1:0] Dato_A;
   logic signed [N-1:0] Dato_B;
   logic                Ocupado;
   logic                Listo;
   logic [2*N-1:0]      Datos_Mult;

   int total;
   int bad;

   multiplicador_secuencial #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Inicio     (Inicio),
      .Dato_A     (Dato_A),
      .Dato_B     (Dato_B),
      .Ocupado    (Ocupado),
      .Listo      (Listo),
      .Datos_Mult (Datos_Mult)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*N-1:0] ref_prod(input logic signed [N-1:0] a,
                                                input logic signed [N-1:0] b);
      longint pa;
      longint pb;
      longint pr;
      pa = longint'(a);
      pb = longint'(b);
      pr = pa * pb;
      return pr[2*N-1:0];
   endfunction

   // Presents operands for exactly one rising edge; returns #1 after that edge.
   task automatic start_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
      @(negedge clk);
      Inicio = 1'b1;
      Dato_A = a;
      Dato_B = b;
      @(posedge clk);
      #1;
      Inicio = 1'b0;
      Dato_A = ~a;
      Dato_B = ~b;
   endtask

   // Counts edges until Listo is seen (-1 if it never comes) and busy samples on the way.
   task automatic wait_listo(output int cyc, output int occ);
      occ = Ocupado ? 1 : 0;
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (Listo) begin
            cyc = i;
            break;
         end
         if (Ocupado) occ++;
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      Inicio = 1'b0;
      Dato_A = '0;
      Dato_B = '0;
      #23;
      total++;
      if ({Ocupado, Listo, Datos_Mult} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got ocup=%b listo=%b prod=%h, want all 0",
                  Ocupado, Listo, Datos_Mult);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({Ocupado, Listo} !== 2'b00) begin
         bad++;
         $display("FAIL reset_idle: got ocup=%b listo=%b, want 0 0", Ocupado, Listo);
      end
   endtask

   task automatic test_directed();
      logic signed [N-1:0] av [4];
      logic signed [N-1:0] bv [4];
      logic [2*N-1:0]      ev [4];
      longint              neg;
      int                  cyc;
      int                  occ;
      neg = -64'sd281474959933440;
      av[0] = 25'sd1572864;   bv[0] = 25'sd32768;    ev[0] = 50'd51539607552;
      av[1] = -25'sd786432;   bv[1] = 25'sd32768;    ev[1] = 50'h3FFFA00000000;
      av[2] = -25'sd16777216; bv[2] = -25'sd16777216; ev[2] = 50'd281474976710656;
      av[3] = 25'sd16777215;  bv[3] = -25'sd16777216; ev[3] = neg[2*N-1:0];
      for (int i = 0; i < 4; i++) begin
         start_op(av[i], bv[i]);
         wait_listo(cyc, occ);
         total++;
         if (cyc !== N) begin
            bad++;
            $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, cyc, N);
         end
         total++;
         if (occ !== N) begin
            bad++;
            $display("FAIL directed_busy[%0d]: got %0d cycles, want %0d", i, occ, N);
         end
         total++;
         if (Datos_Mult !== ev[i] || Ocupado !== 1'b0) begin
            bad++;
            $display("FAIL directed_prod[%0d]: got %h ocup=%b, want %h ocup=0",
                     i, Datos_Mult, Ocupado, ev[i]);
         end
         @(posedge clk);
         #1;
         total++;
         if (Listo !== 1'b0 || Datos_Mult !== ev[i]) begin
            bad++;
            $display("FAIL directed_hold[%0d]: got listo=%b prod=%h, want 0 %h",
                     i, Listo, Datos_Mult, ev[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int cyc;
      int occ;
      start_op(25'sd1572864, 25'sd32768);
      repeat (10) @(posedge clk);
      @(negedge clk);
      Inicio = 1'b1;
      Dato_A = 25'sd12345;
      Dato_B = -25'sd777;
      @(posedge clk);
      #1;
      Inicio = 1'b0;
      wait_listo(cyc, occ);
      total++;
      if (cyc !== N - 11 || Datos_Mult !== 50'd51539607552) begin
         bad++;
         $display("FAIL busy_ignore: got cyc=%0d prod=%h, want cyc=%0d prod=%h",
                  cyc, Datos_Mult, N - 11, 50'd51539607552);
      end
      // Next start lands on the edge right after the Listo cycle.
      start_op(-25'sd786432, 25'sd32768);
      wait_listo(cyc, occ);
      total++;
      if (cyc !== N || Datos_Mult !== 50'h3FFFA00000000) begin
         bad++;
         $display("FAIL back_to_back: got cyc=%0d prod=%h, want cyc=%0d prod=%h",
                  cyc, Datos_Mult, N, 50'h3FFFA00000000);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int occ;
      int seen;
      start_op(25'sd1000, 25'sd3000);
      repeat (12) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if ({Ocupado, Listo, Datos_Mult} !== '0) begin
         bad++;
         $display("FAIL reset_mid_async: got ocup=%b listo=%b prod=%h, want all 0",
                  Ocupado, Listo, Datos_Mult);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (Listo || Ocupado) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL reset_mid_ghost: got %0d active samples, want 0", seen);
      end
      start_op(-25'sd4321, 25'sd98765);
      wait_listo(cyc, occ);
      total++;
      if (cyc !== N || Datos_Mult !== ref_prod(-25'sd4321, 25'sd98765)) begin
         bad++;
         $display("FAIL reset_mid_restart: got cyc=%0d prod=%h, want cyc=%0d prod=%h",
                  cyc, Datos_Mult, N, ref_prod(-25'sd4321, 25'sd98765));
      end
   endtask

   task automatic test_random();
      logic signed [N-1:0] a;
      logic signed [N-1:0] b;
      logic [2*N-1:0]      e;
      int                  cyc;
      int                  occ;
      for (int i = 0; i < 1000; i++) begin
         a = N'($urandom);
         b = N'($urandom);
         if ($urandom_range(0, 15) == 0) a = {1'b1, {(N-1){1'b0}}};
         if ($urandom_range(0, 15) == 0) b = {1'b0, {(N-1){1'b1}}};
         e = ref_prod(a, b);
         start_op(a, b);
         total++;
         if (Listo !== 1'b0 || Ocupado !== 1'b1) begin
            bad++;
            $display("FAIL rand_start[%0d]: got listo=%b ocup=%b, want 0 1",
                     i, Listo, Ocupado);
         end
         wait_listo(cyc, occ);
         total++;
         if (cyc !== N || Datos_Mult !== e) begin
            bad++;
            $display("FAIL rand_prod[%0d]: a=%0d b=%0d got cyc=%0d prod=%h, want cyc=%0d prod=%h",
                     i, a, b, cyc, Datos_Mult, N, e);
         end
         if (cyc < 0) break;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_directed();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multiplicador_secuencial.md
# multiplicador_secuencial

Iterative signed fixed-point multiplier that forms the full-width 2N-bit product feeding the truncation/saturation stage of the datapath. Operand A is Q(5.19) and operand B is Q(10.14), both signed two's complement. The 2N-bit product is therefore a Q(15.33) value. The block uses radix-2 Booth recoding, one step per clock, behind a start/busy/done handshake, so the downstream stage sees a stable, registered product.

## Interface
- N, 25, operand width in bits (sign included). The product is 2N bits.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Inicio  in  1  start request; sampled only in IDLE.
- Dato_A  in  N  signed multiplicand, Q(5.19); sampled with Inicio.
- Dato_B  in  N  signed multiplier, Q(10.14); sampled with Inicio.
- Ocupado  out  1  high while a multiplication is in progress.
- Listo  out  1  one-cycle pulse; Datos_Mult is updated in that cycle.
- Datos_Mult  out  2N  registered signed product, Q(15.33); held until the next completion.

## Operation
- States: IDLE, CALC.
- IDLE:
  - Inicio=1 at a rising edge: latch Dato_A into the multiplicand register M (N bits).
  - Load the accumulator P = {N'b0, Dato_B, 1'b0} (2N+1 bits).
  - Load counter = N, go to CALC, set Ocupado=1.
- CALC, one Booth step per edge:
  - Inspect P[1:0]. 01: add M to P[2N:N+1]. 10: subtract M. 00/11: no operation.
  - The add/subtract is N-bit, with M and the result sign-extended to N+1 bits.
  - Then arithmetic-shift P right by 1, preserving the sign bit P[2N].
  - Decrement counter.
- On the step edge where the counter goes 1→0:
  - Datos_Mult ← P_next[2N:1] (exact 2N-bit two's-complement product).
  - Listo ← 1, Ocupado ← 0, state ← IDLE.
- Listo clears on the following edge unless a new completion occurs.
- Inicio is ignored while in CALC. Dato_A/Dato_B may change freely after the start edge.
- Datos_Mult is never modified except at completion or reset.
- The product is exact for all operand pairs, including A=B=−2^(N−1), which gives +2^(2N−2): bit 2N−1=0, bit 2N−2=1. Range handling is owned by the downstream stage.
- Reset (rst_n=0, at any time including mid-CALC) acts immediately and asynchronously:
  - state=IDLE, counter=0, M=0, P=0.
  - Datos_Mult=0, Listo=0, Ocupado=0.
  - Any in-flight operation is discarded. No Listo is produced for it after reset release.

## Timing
- Start accepted at edge k; Ocupado high from edge k to edge k+N.
- Listo=1 and Datos_Mult valid from edge k+N; Listo low again at edge k+N+1.
- Latency: N cycles from the start edge (25 for the default).
- Back-to-back operation:
  - The block is in IDLE during the Listo cycle.
  - Inicio=1 at edge k+N+1 starts the next operation.
  - Throughput is one product per N+1 cycles.
- Inicio held continuously high: the block restarts on every IDLE edge using the operands present at that edge.
- Simultaneous Inicio and the completion edge: Inicio is not accepted on that edge because the state is still CALC when sampled.
- Outputs are purely registered, with no combinational path from inputs to outputs.

## Test plan
- 3.0 × 2.0:
  - Stimulus: reset, then Inicio with Dato_A=1572864 (3<<19), Dato_B=32768 (2<<14).
  - Response: Listo exactly 25 cycles after the start edge; Datos_Mult=51539607552 (6.0·2^33).
  - Ocupado high for exactly 25 cycles.
- −1.5 × 2.0:
  - Stimulus: Dato_A=−786432, Dato_B=32768.
  - Response: Datos_Mult = −25769803776 as 50-bit two's complement (0x3FFFA00000000).
- Extreme operands:
  - Stimulus: Dato_A=Dato_B=−16777216.
  - Response: Datos_Mult=281474976710656 (bit 48 set, bit 49 clear).
  - Stimulus: Dato_A=16777215, Dato_B=−16777216.
  - Response: exact negative product −281474959933440.
- Start while busy:
  - Stimulus: Inicio pulsed with new operands 10 cycles into CALC.
  - Response: ignored; result and Listo timing match the first operands only.
  - Stimulus: Inicio at edge k+26 (the cycle after Listo).
  - Response: second product completes at edge k+51.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously 12 cycles into CALC, then release.
  - Response: all outputs 0 immediately; no Listo pulse after release.
  - Stimulus: a fresh start after release.
  - Response: correct result in 25 cycles.
- Randomized sweep:
  - Stimulus: 1000 random signed operand pairs, back-to-back starts.
  - Response: every Datos_Mult matches the reference product A·B; exactly one Listo per accepted start.
